// File: rtl/aes_128_feeder_pkg.sv
// Shared widths, latency default and block/word types
// for the aes_128 input feeder.
package aes_pkg;

  localparam int AES_BLK_W         = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = 4;
  localparam int AES_128_LATENCY   = 21;

  typedef logic [AES_BLK_W-1:0]  aes_block_t;
  typedef logic [AES_WORD_W-1:0] aes_word_t;

endpackage

// File: rtl/aes_128_feeder_if.sv
// Plaintext word stream handshake into the feeder.
// The producer drives valid/word, the feeder answers with ready.
interface aes_128_feeder_if;
  import aes_pkg::*;

  logic      in_valid;
  logic      in_ready;
  aes_word_t in_word;

  modport master (
    output in_valid,
    output in_word,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_word,
    output in_ready
  );

endinterface

// File: rtl/aes_128_feeder_lat_tracker.sv
// Fixed-depth {valid, tag} shift register that mirrors the
// aes_128 pipeline so results can be flagged on the right cycle.
module aes_lat_tracker #(
  parameter int DEPTH = 21,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0][W:0] sr_q;
  logic [DEPTH-1:0][W:0] sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = {in_valid, in_data};
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_valid = sr_q[DEPTH-1][W];
  assign out_data  = sr_q[DEPTH-1][W-1:0];

endmodule

// File: rtl/aes_128_feeder.sv
// Packs 32-bit words into aes_128 blocks, holds the key, tracks
// blocks through the core and throttles launches with credits.
module aes_128_feeder
  import aes_pkg::*;
#(
  parameter int AES_LATENCY = AES_128_LATENCY,
  parameter int CREDITS     = 8,
  parameter int SEQ_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_128_feeder_if.slave  in_if,
  input  logic             key_we,
  input  aes_block_t       key_in,
  input  logic             credit_ret,
  output aes_block_t       aes_state,
  output aes_block_t       aes_key,
  output logic             aes_valid,
  output logic             out_valid,
  output logic [SEQ_W-1:0] out_seq,
  output logic             credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [1:0] LAST_WORD = 2'(AES_WORDS_PER_BLK - 1);
  localparam int KEEP_W = AES_BLK_W - AES_WORD_W;

  logic [1:0]       word_cnt_q, word_cnt_d;
  aes_block_t       pack_q, pack_d;
  aes_block_t       state_q, state_d;
  aes_block_t       akey_q, akey_d;
  aes_block_t       hold_q, hold_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    cred_q, cred_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  logic ready;
  logic accept;
  logic launch;
  logic full;

  assign ready  = !(word_cnt_q == LAST_WORD && cred_q == '0);
  assign accept = in_if.in_valid && ready;
  assign launch = accept && word_cnt_q == LAST_WORD;
  assign full   = cred_q == CRED_MAX;

  always_comb begin
    word_cnt_d = word_cnt_q;
    pack_d     = pack_q;
    state_d    = state_q;
    akey_d     = akey_q;
    hold_d     = hold_q;
    valid_d    = 1'b0;
    cred_d     = cred_q;
    seq_d      = seq_q;
    tag_d      = tag_q;
    err_d      = err_q;

    if (accept) begin
      word_cnt_d = word_cnt_q + 2'd1;
      pack_d     = {pack_q[KEEP_W-1:0], in_if.in_word};
    end

    // key_d samples the hold register before this edge's key_we
    if (launch) begin
      state_d = {pack_q[KEEP_W-1:0], in_if.in_word};
      akey_d  = hold_q;
      valid_d = 1'b1;
      tag_d   = seq_q;
      seq_d   = seq_q + SEQ_W'(1);
    end

    if (key_we) begin
      hold_d = key_in;
    end

    unique case (1'b1)
      launch && !credit_ret: cred_d = cred_q - CW'(1);
      !launch && credit_ret && full: err_d = 1'b1;
      !launch && credit_ret && !full: cred_d = cred_q + CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      pack_q     <= '0;
      state_q    <= '0;
      akey_q     <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      cred_q     <= CRED_MAX;
      seq_q      <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      pack_q     <= pack_d;
      state_q    <= state_d;
      akey_q     <= akey_d;
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      cred_q     <= cred_d;
      seq_q      <= seq_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
    end
  end

  aes_lat_tracker #(
    .DEPTH (AES_LATENCY),
    .W     (SEQ_W)
  ) u_lat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (valid_q),
    .in_data   (tag_q),
    .out_valid (out_valid),
    .out_data  (out_seq)
  );

  assign in_if.in_ready = ready;
  assign aes_state      = state_q;
  assign aes_key        = akey_q;
  assign aes_valid      = valid_q;
  assign credit_err     = err_q;

endmodule
